br_issue_queue: RTL

// - Branch/jump reservation station directly upstream of the branch-resolution unit: holds dispatched
//   UOP_BRANCH/UOP_JUMP uops and tracks source-operand readiness via physical-register wakeup.
// - Issues the oldest ready uop (ROB age) to the BRU through a valid/ready handshake; the register file

---
 rtl/br_issue_queue_pkg.sv | 35 +++
 rtl/br_iq_oldest_sel.sv | 27 ++
 rtl/br_issue_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/br_issue_queue_pkg.sv
// Shared types for branch-side reservation stations: uop bundle, ROB/PRF widths
// and the ROB-relative age helper used by every age-ordered queue.
package br_issue_queue_pkg;
  localparam int ROB_W  = 4;
  localparam int PHYS_W = 6;

  typedef enum logic [1:0] {
    UOP_ALU, UOP_BRANCH, UOP_JUMP, UOP_MEM
  } uop_class_e;

  typedef enum logic [2:0] {
    BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
  } branch_type_e;

  typedef struct packed {
    uop_class_e   uop_class;
    branch_type_e br_type;
    logic         uses_rs1;
    logic         uses_rs2;
    logic [11:0]  imm;
  } uop_bundle_t;

  typedef struct packed {
    uop_bundle_t       bundle;
    logic [1:0]        epoch;
    logic [ROB_W-1:0]  rob_idx;
    logic [PHYS_W-1:0] prd_new;
  } rs_uop_t;

  // Distance from the ROB head; smaller means older. Wraps naturally mod 2^ROB_W.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                               input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction
endpackage

// File: rtl/br_iq_oldest_sel.sv
// Combinational N-way oldest-candidate picker: one-hot grant of the minimum age
// among the candidate mask, plus an any-candidate flag.
module br_iq_oldest_sel #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic [N-1:0]         i_cand,
  input  logic [N-1:0][AW-1:0] i_age,
  output logic [N-1:0]         o_grant,
  output logic                 o_any
);
  logic [AW-1:0] w_best_age;

  always_comb begin
    o_grant    = '0;
    o_any      = 1'b0;
    w_best_age = '1;
    for (int i = 0; i < N; i++) begin
      if (i_cand[i] && (!o_any || i_age[i] < w_best_age)) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_any      = 1'b1;
        w_best_age = i_age[i];
      end
    end
  end
endmodule

// File: rtl/br_issue_queue.sv
// Branch/jump reservation station: tracks operand readiness via tag wakeup,
// issues the oldest ready uop to the BRU and drops younger entries on flush.
module br_issue_queue
  import br_issue_queue_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int WAKE_PORTS = 2,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_enq_valid,
  output logic                                 o_enq_ready,
  input  rs_uop_t                              i_enq_uop,
  input  logic [PHYS_W-1:0]                    i_enq_prs1,
  input  logic [PHYS_W-1:0]                    i_enq_prs2,
  input  logic                                 i_enq_rdy1,
  input  logic                                 i_enq_rdy2,
  input  logic [WAKE_PORTS-1:0]                i_wk_valid,
  input  logic [WAKE_PORTS-1:0][PHYS_W-1:0]    i_wk_preg,
  output logic                                 o_iss_valid,
  input  logic                                 i_iss_ready,
  output rs_uop_t                              o_iss_uop,
  output logic [PHYS_W-1:0]                    o_iss_prs1,
  output logic [PHYS_W-1:0]                    o_iss_prs2,
  input  logic [ROB_W-1:0]                     i_rob_head,
  input  logic                                 i_flush_valid,
  input  logic [ROB_W-1:0]                     i_flush_rob_idx,
  output logic [OCC_W-1:0]                     o_occupancy
);
  logic [DEPTH-1:0]             r_vld, r_rdy1, r_rdy2;
  rs_uop_t [DEPTH-1:0]          r_uop;
  logic [DEPTH-1:0][PHYS_W-1:0] r_prs1, r_prs2;
  logic [OCC_W-1:0]             r_occ;

  logic [DEPTH-1:0]             w_wk1, w_wk2, w_cand, w_kill, w_grant, w_free_oh, w_vld_nxt;
  logic [DEPTH-1:0][ROB_W-1:0]  w_age;
  logic [ROB_W-1:0]             w_flush_age;
  logic [OCC_W-1:0]             w_occ_nxt;
  logic                         w_enq_wk1, w_enq_wk2, w_any, w_iss_fire, w_enq_fire;

  // Tag match for stored entries and for the uop being written this cycle.
  always_comb begin
    w_wk1     = '0;
    w_wk2     = '0;
    w_enq_wk1 = 1'b0;
    w_enq_wk2 = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (i_wk_valid[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_vld[i] && r_prs1[i] == i_wk_preg[p]) w_wk1[i] = 1'b1;
          if (r_vld[i] && r_prs2[i] == i_wk_preg[p]) w_wk2[i] = 1'b1;
        end
        if (i_enq_prs1 == i_wk_preg[p]) w_enq_wk1 = 1'b1;
        if (i_enq_prs2 == i_wk_preg[p]) w_enq_wk2 = 1'b1;
      end
    end
  end

  assign w_flush_age = rob_age(i_flush_rob_idx, i_rob_head);

  always_comb begin
    w_age  = '0;
    w_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_age[i]  = rob_age(r_uop[i].rob_idx, i_rob_head);
      w_kill[i] = r_vld[i] && (w_age[i] > w_flush_age);
    end
  end

  assign w_cand = r_vld & r_rdy1 & r_rdy2;

  br_iq_oldest_sel #(.N(DEPTH), .AW(ROB_W)) u_sel (
    .i_cand  (w_cand),
    .i_age   (w_age),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign o_iss_valid = !i_rst && !i_flush_valid && w_any;
  assign o_enq_ready = !i_rst && !i_flush_valid && (r_occ < OCC_W'(DEPTH));
  assign w_iss_fire  = o_iss_valid && i_iss_ready;
  assign w_enq_fire  = i_enq_valid && o_enq_ready;
  // Lowest clear bit of the valid mask; slot freed by this cycle's issue is not reused.
  assign w_free_oh   = ~r_vld & (r_vld + DEPTH'(1));
  assign o_occupancy = r_occ;

  always_comb begin
    o_iss_uop  = '0;
    o_iss_prs1 = '0;
    o_iss_prs2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        o_iss_uop  = r_uop[i];
        o_iss_prs1 = r_prs1[i];
        o_iss_prs2 = r_prs2[i];
      end
    end
  end

  always_comb begin
    w_vld_nxt = r_vld;
    if (i_flush_valid) begin
      w_vld_nxt = r_vld & ~w_kill;
    end else begin
      if (w_iss_fire) w_vld_nxt = w_vld_nxt & ~w_grant;
      if (w_enq_fire) w_vld_nxt = w_vld_nxt | w_free_oh;
    end
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_occ_nxt = w_occ_nxt + OCC_W'(w_vld_nxt[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_occ <= '0;
    end else begin
      r_vld  <= w_vld_nxt;
      r_occ  <= w_occ_nxt;
      r_rdy1 <= r_rdy1 | w_wk1;
      r_rdy2 <= r_rdy2 | w_wk2;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_enq_fire && w_free_oh[i]) begin
          r_uop[i]  <= i_enq_uop;
          r_prs1[i] <= i_enq_prs1;
          r_prs2[i] <= i_enq_prs2;
          r_rdy1[i] <= i_enq_rdy1 || !i_enq_uop.bundle.uses_rs1 || w_enq_wk1;
          r_rdy2[i] <= i_enq_rdy2 || !i_enq_uop.bundle.uses_rs2 || w_enq_wk2;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_enq_valid)
      assert (i_enq_uop.bundle.uop_class inside {UOP_BRANCH, UOP_JUMP});
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (!i_rst && r_vld[i] && r_vld[j])
          assert (r_uop[i].rob_idx != r_uop[j].rob_idx);
  end
endmodule
